// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared FSM, source and report-packet definitions for the UART-0 transmit scheduler
package uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT
  } tx_state_t;

  typedef enum logic {
    SRC_ECHO,
    SRC_REPORT
  } tx_src_t;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;
  localparam logic [2:0] REPORT_LEN_BASE  = 3'd6;
  localparam logic [2:0] REPORT_LEN_CSUM  = 3'd7;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [1:0]  alg;
    logic        vf;
  } report_snap_t;

endpackage

// File: rtl/uart_tx_echo_fifo.sv
// rtl/uart_tx_echo_fifo.sv - synchronous byte FIFO queueing echo bytes for the UART-0 transmitter
module uart_tx_echo_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     sys_clk_96M,
  input  logic                     sys_rst_n,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Full comes from the registered count, so a push while full is dropped even alongside a pop.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge sys_clk_96M) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge sys_clk_96M or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - shares UART-0 between echo bytes and status packets with a tx watchdog
// Optional build macro UART_TX_CHECKSUM_EN appends an XOR checksum byte to each status packet.
module uart_tx_scheduler import uart_tx_pkg::*; #(
  parameter int          ECHO_DEPTH  = 16,
  parameter logic [7:0]  HDR_BYTE    = HDR_BYTE_DEFAULT,
  parameter logic [19:0] TIMEOUT_CYC = 20'd200000
) (
  input  logic        sys_clk_96M,
  input  logic        sys_rst_n,
  input  logic        echo_valid,
  input  logic [7:0]  echo_data,
  input  logic        report_req,
  input  logic [11:0] x_pix_len,
  input  logic [11:0] y_pix_len,
  input  logic [1:0]  algorithm,
  input  logic        vid_format,
  output logic        txd_en,
  output logic [7:0]  txd_data,
  input  logic        txd_flag,
  output logic        busy,
  output logic        echo_overflow,
  output logic        tx_timeout
);

`ifdef UART_TX_CHECKSUM_EN
  localparam logic [2:0] REPORT_LEN = REPORT_LEN_CSUM;
`else
  localparam logic [2:0] REPORT_LEN = REPORT_LEN_BASE;
`endif
  localparam logic [2:0] LAST_IDX = REPORT_LEN - 3'd1;

  tx_state_t    state;
  tx_src_t      src;
  tx_src_t      last_src;
  report_snap_t snap;
  logic         report_pend;
  logic [2:0]   byte_idx;
  logic [19:0]  wdog;
  logic [7:0]   report_byte;

  logic                          fifo_pop;
  logic [7:0]                    fifo_head;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [$clog2(ECHO_DEPTH):0]   fifo_count;

  assign fifo_pop = (state == ST_LOAD) && (src == SRC_ECHO);
  assign busy     = (state != ST_IDLE);

  uart_tx_echo_fifo #(.DEPTH(ECHO_DEPTH)) u_echo_fifo (
    .sys_clk_96M (sys_clk_96M),
    .sys_rst_n   (sys_rst_n),
    .push        (echo_valid),
    .push_data   (echo_data),
    .pop         (fifo_pop),
    .head        (fifo_head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count       (fifo_count)
  );

`ifdef UART_TX_CHECKSUM_EN
  logic [7:0] csum;
  assign csum = {4'h0, snap.x[11:8]} ^ snap.x[7:0] ^ {4'h0, snap.y[11:8]} ^ snap.y[7:0]
              ^ {5'b0, snap.vf, snap.alg};
`endif

  always_comb begin
    report_byte = 8'h00;
    case (byte_idx)
      3'd0: report_byte = HDR_BYTE;
      3'd1: report_byte = {4'h0, snap.x[11:8]};
      3'd2: report_byte = snap.x[7:0];
      3'd3: report_byte = {4'h0, snap.y[11:8]};
      3'd4: report_byte = snap.y[7:0];
      3'd5: report_byte = {5'b0, snap.vf, snap.alg};
`ifdef UART_TX_CHECKSUM_EN
      3'd6: report_byte = csum;
`endif
      default: report_byte = 8'h00;
    endcase
  end

  always_ff @(posedge sys_clk_96M or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= ST_IDLE;
      src           <= SRC_ECHO;
      last_src      <= SRC_ECHO;
      snap          <= '0;
      report_pend   <= 1'b0;
      byte_idx      <= 3'd0;
      wdog          <= 20'd0;
      txd_en        <= 1'b0;
      txd_data      <= 8'h00;
      echo_overflow <= 1'b0;
      tx_timeout    <= 1'b0;
    end else begin
      echo_overflow <= echo_valid && fifo_full;
      txd_en        <= 1'b0;
      if (report_req) report_pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          // Report goes first unless the previous grant was also a report and echo bytes are waiting.
          if (report_pend && (last_src == SRC_ECHO || fifo_count == '0)) begin
            src      <= SRC_REPORT;
            last_src <= SRC_REPORT;
            snap     <= '{x: x_pix_len, y: y_pix_len, alg: algorithm, vf: vid_format};
            byte_idx <= 3'd0;
            if (!report_req) report_pend <= 1'b0;
            state    <= ST_LOAD;
          end else if (!fifo_empty) begin
            src      <= SRC_ECHO;
            last_src <= SRC_ECHO;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          txd_data <= (src == SRC_REPORT) ? report_byte : fifo_head;
          txd_en   <= 1'b1;
          state    <= ST_SEND;
        end
        ST_SEND: begin
          wdog  <= 20'd0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (txd_flag) begin
            if (src == SRC_REPORT && byte_idx != LAST_IDX) begin
              byte_idx <= byte_idx + 3'd1;
              state    <= ST_LOAD;
            end else begin
              txd_data <= 8'h00;
              state    <= ST_IDLE;
            end
          end else if (wdog == TIMEOUT_CYC - 20'd1) begin
            tx_timeout <= 1'b1;
            txd_data   <= 8'h00;
            state      <= ST_IDLE;
          end else begin
            wdog <= wdog + 20'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed self-checking bench for uart_tx_scheduler
// Honours UART_TX_CHECKSUM_EN to expect the 7-byte packet variant.
module tb_uart_tx_scheduler;

  localparam logic [19:0] TMO = 20'd1000;
`ifdef UART_TX_CHECKSUM_EN
  localparam int PKT_LEN = 7;
`else
  localparam int PKT_LEN = 6;
`endif

  logic        sys_clk_96M = 1'b0;
  logic        sys_rst_n   = 1'b0;
  logic        echo_valid  = 1'b0;
  logic [7:0]  echo_data   = 8'h00;
  logic        report_req  = 1'b0;
  logic [11:0] x_pix_len   = 12'h000;
  logic [11:0] y_pix_len   = 12'h000;
  logic [1:0]  algorithm   = 2'd0;
  logic        vid_format  = 1'b0;
  logic        txd_en;
  logic [7:0]  txd_data;
  logic        txd_flag    = 1'b0;
  logic        busy;
  logic        echo_overflow;
  logic        tx_timeout;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] pkt1 [7] = '{8'hA5, 8'h07, 8'h80, 8'h04, 8'h38, 8'h06, 8'hBD};
  logic [7:0] pkt2 [7] = '{8'hA5, 8'h01, 8'h23, 8'h0A, 8'hBC, 8'h01, 8'h95};
  logic [7:0] exp_q [$];

  logic [7:0] rx_q [$];
  logic       resp_en     = 1'b1;
  int         resp_delay  = 100;
  int         flag_cnt    = 0;
  logic       outstanding = 1'b0;
  logic [7:0] held        = 8'h00;
  int         ovf_cnt     = 0;

  uart_tx_scheduler #(
    .ECHO_DEPTH  (16),
    .HDR_BYTE    (8'hA5),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .sys_clk_96M   (sys_clk_96M),
    .sys_rst_n     (sys_rst_n),
    .echo_valid    (echo_valid),
    .echo_data     (echo_data),
    .report_req    (report_req),
    .x_pix_len     (x_pix_len),
    .y_pix_len     (y_pix_len),
    .algorithm     (algorithm),
    .vid_format    (vid_format),
    .txd_en        (txd_en),
    .txd_data      (txd_data),
    .txd_flag      (txd_flag),
    .busy          (busy),
    .echo_overflow (echo_overflow),
    .tx_timeout    (tx_timeout)
  );

  always #5 sys_clk_96M = ~sys_clk_96M;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // UART transmitter model: captures each started byte and returns txd_flag after resp_delay cycles.
  always @(negedge sys_clk_96M) begin
    txd_flag = 1'b0;
    if (echo_overflow === 1'b1) ovf_cnt++;
    if (busy !== 1'b1) outstanding = 1'b0;
    if (txd_en === 1'b1) begin
      rx_q.push_back(txd_data);
      held        = txd_data;
      outstanding = 1'b1;
      flag_cnt    = resp_delay;
    end else if (outstanding && resp_en) begin
      if (flag_cnt > 0) flag_cnt--;
      if (flag_cnt == 0) begin
        check("txd_data_stable", {24'h0, txd_data}, {24'h0, held});
        txd_flag    = 1'b1;
        outstanding = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk_96M);
    #1;
  endtask

  task automatic send_report(input logic [11:0] x, input logic [11:0] y, input logic [1:0] a,
                             input logic v);
    x_pix_len = x; y_pix_len = y; algorithm = a; vid_format = v;
    report_req = 1'b1;
    tick(1);
    report_req = 1'b0;
  endtask

  task automatic send_echo(input logic [7:0] d);
    echo_valid = 1'b1; echo_data = d;
    tick(1);
    echo_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int i = 0;
    while (rx_q.size() < n && i < budget) begin tick(1); i++; end
    check(tag, rx_q.size(), n);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int i = 0;
    while (busy !== 1'b0 && i < budget) begin tick(1); i++; end
    check(tag, {31'h0, busy}, 32'h0);
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), {24'h0, rx_q[i]}, {24'h0, exp_q[i]});
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    tick(3);
    sys_rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    // reset values
    tick(2);
    check("rst_txd_en", {31'h0, txd_en}, 32'h0);
    check("rst_txd_data", {24'h0, txd_data}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_overflow", {31'h0, echo_overflow}, 32'h0);
    check("rst_timeout", {31'h0, tx_timeout}, 32'h0);
    sys_rst_n = 1'b1;
    tick(2);

    // single status packet, 100-cycle UART turnaround
    rx_q.delete(); exp_q.delete();
    for (int i = 0; i < PKT_LEN; i++) exp_q.push_back(pkt1[i]);
    send_report(12'h780, 12'h438, 2'd2, 1'b1);
    wait_rx(PKT_LEN, 2000, "pkt1_wait");
    wait_idle(300, "pkt1_idle");
    check_rx("pkt1");
    check("pkt1_data_idle", {24'h0, txd_data}, 32'h0);

    // echo latency: valid in cycle N -> txd_en in cycle N+3
    rx_q.delete();
    resp_delay = 4;
    echo_valid = 1'b1; echo_data = 8'h3C;
    tick(1);
    echo_valid = 1'b0;
    check("lat_n1", {31'h0, txd_en}, 32'h0);
    tick(1);
    check("lat_n2", {31'h0, txd_en}, 32'h0);
    tick(1);
    check("lat_n3_en", {31'h0, txd_en}, 32'h1);
    check("lat_n3_data", {24'h0, txd_data}, 32'h3C);
    wait_idle(100, "lat_idle");

    // 19 back-to-back echoes with UART stalled: 1 in flight + 16 queued, 2 dropped
    rx_q.delete(); exp_q.delete();
    resp_en = 1'b0; ovf_cnt = 0;
    for (int i = 0; i < 19; i++) begin
      echo_valid = 1'b1; echo_data = 8'h10 + 8'(i);
      tick(1);
    end
    echo_valid = 1'b0;
    tick(3);
    check("ovf_pulses", ovf_cnt, 2);
    check("ovf_in_flight", rx_q.size(), 1);
    resp_en = 1'b1;
    for (int i = 0; i < 17; i++) exp_q.push_back(8'h10 + 8'(i));
    wait_rx(17, 400, "ovf_wait");
    wait_idle(100, "ovf_idle");
    tick(10);
    check_rx("ovf");

    // arbitration: packet, echo, re-requested packet, echo, echo
    do_reset();
    rx_q.delete(); exp_q.delete();
    resp_delay = 6;
    x_pix_len = 12'h123; y_pix_len = 12'hABC; algorithm = 2'd1; vid_format = 1'b0;
    report_req = 1'b1; echo_valid = 1'b1; echo_data = 8'hE1;
    tick(1);
    report_req = 1'b0; echo_data = 8'hE2;
    tick(1);
    echo_data = 8'hE3;
    tick(1);
    echo_valid = 1'b0;
    wait_rx(PKT_LEN + 1, 300, "arb_first");
    report_req = 1'b1;
    tick(1);
    report_req = 1'b0;
    for (int i = 0; i < PKT_LEN; i++) exp_q.push_back(pkt2[i]);
    exp_q.push_back(8'hE1);
    for (int i = 0; i < PKT_LEN; i++) exp_q.push_back(pkt2[i]);
    exp_q.push_back(8'hE2);
    exp_q.push_back(8'hE3);
    wait_rx(2 * PKT_LEN + 3, 400, "arb_wait");
    wait_idle(100, "arb_idle");
    check_rx("arb");

    // watchdog: UART never answers
    rx_q.delete();
    resp_en = 1'b0;
    send_report(12'h780, 12'h438, 2'd2, 1'b1);
    wait_rx(1, 20, "tmo_start");
    tick(500);
    check("tmo_not_yet", {31'h0, tx_timeout}, 32'h0);
    check("tmo_busy_mid", {31'h0, busy}, 32'h1);
    wait_idle(700, "tmo_idle");
    check("tmo_flag", {31'h0, tx_timeout}, 32'h1);
    check("tmo_data", {24'h0, txd_data}, 32'h0);
    check("tmo_aborted", rx_q.size(), 1);
    resp_en = 1'b1; resp_delay = 5;
    send_echo(8'h5A);
    wait_rx(2, 50, "tmo_next_wait");
    wait_idle(50, "tmo_next_idle");
    check("tmo_next_byte", {24'h0, rx_q[1]}, 32'h5A);
    check("tmo_sticky", {31'h0, tx_timeout}, 32'h1);

    // async reset during third packet byte, no resume
    rx_q.delete();
    resp_delay = 20;
    send_report(12'h780, 12'h438, 2'd2, 1'b1);
    wait_rx(3, 200, "ar_third");
    tick(2);
    sys_rst_n = 1'b0;
    #1;
    check("ar_txd_en", {31'h0, txd_en}, 32'h0);
    check("ar_txd_data", {24'h0, txd_data}, 32'h0);
    check("ar_busy", {31'h0, busy}, 32'h0);
    check("ar_timeout", {31'h0, tx_timeout}, 32'h0);
    check("ar_overflow", {31'h0, echo_overflow}, 32'h0);
    tick(3);
    sys_rst_n = 1'b1;
    tick(200);
    check("ar_no_resume", rx_q.size(), 3);
    check("ar_idle", {31'h0, busy}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
